// File: rtl/full_adder_resp.sv
// full_adder_resp: responder end of the valid-handshake adder bus.
// Each accepted beat is summed as a 1-bit full add at capture time. The result
// and the echoed operands then travel through LATENCY register stages.
// A saturating counter tallies every beat that leaves the pipeline.
module full_adder_resp #(
    parameter int LATENCY = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [2:0]         data_bus_in,
    output logic               valid_out,
    output logic [4:0]         data_bus_out,
    output logic [COUNT_W-1:0] txn_count
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "full_adder_resp: LATENCY must be in 1..8");
    end
    if (COUNT_W < 2 || COUNT_W > 32) begin : g_bad_count_w
        $fatal(1, "full_adder_resp: COUNT_W must be in 2..32");
    end

    // {cout, s, cin, b, a} from {cin, b, a}
    function automatic logic [4:0] full_add(input logic [2:0] abc);
        logic a;
        logic b;
        logic cin;
        logic s;
        logic cout;
        a    = abc[0];
        b    = abc[1];
        cin  = abc[2];
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
        return {cout, s, cin, b, a};
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [4:0]         word_p0;
    logic [LATENCY-1:0] vld_p;
    logic [4:0]         word_p [LATENCY];
    logic               exit_vld;
    logic [COUNT_W-1:0] count;

    // Stage 0: combinational full add on the incoming operands
    always_comb begin
        word_p0 = full_add(data_bus_in);
    end

    // The valid bit entering the final stage marks the edge a beat exits
    if (LATENCY == 1) begin : g_exit_direct
        assign exit_vld = valid_in;
    end else begin : g_exit_piped
        assign exit_vld = vld_p[LATENCY-2];
    end

    // Pipeline stages 1..LATENCY; words move only with a valid bit so every
    // stage, including the output one, holds its last real beat across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                word_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= valid_in;
            if (valid_in) begin
                word_p[0] <= word_p0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) begin
                    word_p[i] <= word_p[i-1];
                end
            end
        end
    end

    // Completed-transaction counter, stepping on the edge that raises valid_out
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (exit_vld) begin
            count <= sat_inc(count);
        end
    end

    // Final stage drives the bus directly
    assign valid_out    = vld_p[LATENCY-1];
    assign data_bus_out = word_p[LATENCY-1];
    assign txn_count    = count;

endmodule

// File: tb/tb_full_adder_resp.sv
// Bench for full_adder_resp: five instances with different LATENCY/COUNT_W
// share one stimulus bus; a history-based reference model predicts every output.
module tb_full_adder_resp;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [2:0] data_bus_in;

    logic        v_a, v_b, v_c, v_d, v_e;
    logic [4:0]  d_a, d_b, d_c, d_d, d_e;
    logic [15:0] c_a, c_b, c_c, c_d;
    logic [1:0]  c_e;

    logic        ov [5];
    logic [4:0]  od [5];
    logic [31:0] oc [5];

    int lat_tab [5] = '{2, 1, 4, 8, 2};
    int cw_tab  [5] = '{16, 16, 16, 16, 2};

    int checks = 0;
    int errors = 0;

    // stimulus history, one entry per rising edge
    int         ne = 0;
    bit         h_rst [4096];
    bit         h_v   [4096];
    logic [2:0] h_d   [4096];

    always #5 clk = ~clk;

    full_adder_resp #(.LATENCY(2), .COUNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_bus_in(data_bus_in),
        .valid_out(v_a), .data_bus_out(d_a), .txn_count(c_a));
    full_adder_resp #(.LATENCY(1), .COUNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_bus_in(data_bus_in),
        .valid_out(v_b), .data_bus_out(d_b), .txn_count(c_b));
    full_adder_resp #(.LATENCY(4), .COUNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_bus_in(data_bus_in),
        .valid_out(v_c), .data_bus_out(d_c), .txn_count(c_c));
    full_adder_resp #(.LATENCY(8), .COUNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_bus_in(data_bus_in),
        .valid_out(v_d), .data_bus_out(d_d), .txn_count(c_d));
    full_adder_resp #(.LATENCY(2), .COUNT_W(2)) dut_e (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_bus_in(data_bus_in),
        .valid_out(v_e), .data_bus_out(d_e), .txn_count(c_e));

    assign ov[0] = v_a;  assign od[0] = d_a;  assign oc[0] = {16'b0, c_a};
    assign ov[1] = v_b;  assign od[1] = d_b;  assign oc[1] = {16'b0, c_b};
    assign ov[2] = v_c;  assign od[2] = d_c;  assign oc[2] = {16'b0, c_c};
    assign ov[3] = v_d;  assign od[3] = d_d;  assign oc[3] = {16'b0, c_d};
    assign ov[4] = v_e;  assign od[4] = d_e;  assign oc[4] = {30'b0, c_e};

    always @(posedge clk) begin
        if (ne < 4096) begin
            h_rst[ne] <= rst;
            h_v[ne]   <= valid_in;
            h_d[ne]   <= data_bus_in;
            ne        <= ne + 1;
        end
    end

    // word = {two-bit arithmetic sum, operands}
    function automatic logic [4:0] golden(input logic [2:0] d);
        logic [1:0] sm;
        sm = 2'(d[0]) + 2'(d[1]) + 2'(d[2]);
        return {sm, d};
    endfunction

    // Predicted outputs after the most recent edge for a given configuration
    function automatic void model(input int lat, input int cw, output logic ev,
                                  output logic [4:0] ew, output longint ec);
        int     r;
        int     a;
        longint mx;
        r  = -1;
        for (int k = 0; k < ne; k++) if (h_rst[k]) r = k;
        ev = 1'b0;
        ew = 5'b0;
        ec = 0;
        mx = (longint'(1) << cw) - 1;
        for (int k = r + 1; k < ne; k++) begin
            a = k - lat + 1;
            if (a > r && a >= 0 && h_v[a]) begin
                ew = golden(h_d[a]);
                if (ec < mx) ec++;
                if (k == ne - 1) ev = 1'b1;
            end
        end
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [2:0] d);
        rst         = r;
        valid_in    = v;
        data_bus_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic ev; logic [4:0] ew; longint ec;
        for (int t = 0; t < 11; t++) begin
            if (t < 3) cyc(1'b1, t[0], 3'($urandom));
            else       cyc(1'b0, 1'b0, 3'($urandom));
            checks++;
            if (v_a !== 1'b0 || d_a !== 5'b0 || c_a !== 16'd0) begin
                errors++;
                $display("FAIL reset_const t=%0d got v=%b d=%b c=%0d want 0 0 0", t, v_a, d_a, c_a);
            end
            for (int i = 0; i < 5; i++) begin
                model(lat_tab[i], cw_tab[i], ev, ew, ec);
                checks++;
                if (ov[i] !== ev || od[i] !== ew || oc[i] !== ec[31:0]) begin
                    errors++;
                    $display("FAIL reset_model dut%0d t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                             i, t, ov[i], od[i], oc[i], ev, ew, ec);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ev; logic [4:0] ew; longint ec;
        logic [4:0] words [8] = '{5'b00000, 5'b01001, 5'b01010, 5'b10011,
                                  5'b01100, 5'b10101, 5'b10110, 5'b11111};
        logic [4:0] xw;
        logic       xv;
        int         xc;
        cyc(1'b1, 1'b0, 3'b0);
        for (int t = 0; t < 12; t++) begin
            if (t < 8) cyc(1'b0, 1'b1, 3'(t));
            else       cyc(1'b0, 1'b0, 3'($urandom));
            xv = (t >= 1 && t <= 8);
            xw = (t == 0) ? 5'b0 : words[(t > 8) ? 7 : t - 1];
            xc = (t > 8) ? 8 : t;
            checks++;
            if (v_a !== xv || d_a !== xw || c_a !== 16'(xc)) begin
                errors++;
                $display("FAIL exhaustive t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                         t, v_a, d_a, c_a, xv, xw, xc);
            end
            for (int i = 0; i < 5; i++) begin
                model(lat_tab[i], cw_tab[i], ev, ew, ec);
                checks++;
                if (ov[i] !== ev || od[i] !== ew || oc[i] !== ec[31:0]) begin
                    errors++;
                    $display("FAIL exhaustive_model dut%0d t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                             i, t, ov[i], od[i], oc[i], ev, ew, ec);
                end
            end
        end
    endtask

    task automatic test_latency_sweep();
        logic ev; logic [4:0] ew; longint ec;
        int   sw [3] = '{1, 2, 3};
        int   l;
        logic xv;
        logic [4:0] xw;
        cyc(1'b1, 1'b0, 3'b0);
        for (int t = 0; t < 12; t++) begin
            if (t == 0) cyc(1'b0, 1'b1, 3'b101);
            else        cyc(1'b0, 1'b0, 3'($urandom));
            for (int j = 0; j < 3; j++) begin
                l  = lat_tab[sw[j]];
                xv = (t == l - 1);
                xw = (t >= l - 1) ? 5'b10101 : 5'b0;
                checks++;
                if (ov[sw[j]] !== xv || od[sw[j]] !== xw) begin
                    errors++;
                    $display("FAIL latency L=%0d t=%0d got v=%b d=%b want v=%b d=%b",
                             l, t, ov[sw[j]], od[sw[j]], xv, xw);
                end
            end
            for (int i = 0; i < 5; i++) begin
                model(lat_tab[i], cw_tab[i], ev, ew, ec);
                checks++;
                if (ov[i] !== ev || od[i] !== ew || oc[i] !== ec[31:0]) begin
                    errors++;
                    $display("FAIL latency_model dut%0d t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                             i, t, ov[i], od[i], oc[i], ev, ew, ec);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic ev; logic [4:0] ew; longint ec;
        logic xv;
        logic [4:0] xw;
        cyc(1'b1, 1'b0, 3'b0);
        for (int t = 0; t < 9; t++) begin
            case (t)
                0:       cyc(1'b0, 1'b1, 3'b011);
                3:       cyc(1'b0, 1'b1, 3'b100);
                default: cyc(1'b0, 1'b0, 3'($urandom));
            endcase
            xv = (t == 1 || t == 4);
            xw = (t == 0) ? 5'b0 : (t < 4) ? 5'b10011 : 5'b01100;
            checks++;
            if (v_a !== xv || d_a !== xw) begin
                errors++;
                $display("FAIL bubble_hold t=%0d got v=%b d=%b want v=%b d=%b", t, v_a, d_a, xv, xw);
            end
            for (int i = 0; i < 5; i++) begin
                model(lat_tab[i], cw_tab[i], ev, ew, ec);
                checks++;
                if (ov[i] !== ev || od[i] !== ew || oc[i] !== ec[31:0]) begin
                    errors++;
                    $display("FAIL bubble_model dut%0d t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                             i, t, ov[i], od[i], oc[i], ev, ew, ec);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic ev; logic [4:0] ew; longint ec;
        int pulses = 0;
        cyc(1'b1, 1'b0, 3'b0);
        for (int t = 0; t < 11; t++) begin
            if (t < 3)       cyc(1'b0, 1'b1, 3'($urandom));
            else if (t == 5) cyc(1'b1, 1'b0, 3'($urandom));
            else             cyc(1'b0, 1'b0, 3'($urandom));
            if (v_c === 1'b1) pulses++;
            for (int i = 0; i < 5; i++) begin
                model(lat_tab[i], cw_tab[i], ev, ew, ec);
                checks++;
                if (ov[i] !== ev || od[i] !== ew || oc[i] !== ec[31:0]) begin
                    errors++;
                    $display("FAIL midflight_model dut%0d t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                             i, t, ov[i], od[i], oc[i], ev, ew, ec);
                end
            end
        end
        checks++;
        if (pulses != 2 || c_c !== 16'd0) begin
            errors++;
            $display("FAIL midflight_total got pulses=%0d count=%0d want pulses=2 count=0", pulses, c_c);
        end
    endtask

    task automatic test_saturation();
        logic ev; logic [4:0] ew; longint ec;
        int pulses = 0;
        int xc;
        cyc(1'b1, 1'b0, 3'b0);
        for (int t = 0; t < 10; t++) begin
            if (t < 6) cyc(1'b0, 1'b1, 3'($urandom));
            else       cyc(1'b0, 1'b0, 3'($urandom));
            if (v_e === 1'b1) pulses++;
            xc = (t == 0) ? 0 : (t > 3) ? 3 : t;
            checks++;
            if (c_e !== 2'(xc)) begin
                errors++;
                $display("FAIL saturation t=%0d got count=%0d want %0d", t, c_e, xc);
            end
            for (int i = 0; i < 5; i++) begin
                model(lat_tab[i], cw_tab[i], ev, ew, ec);
                checks++;
                if (ov[i] !== ev || od[i] !== ew || oc[i] !== ec[31:0]) begin
                    errors++;
                    $display("FAIL saturation_model dut%0d t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                             i, t, ov[i], od[i], oc[i], ev, ew, ec);
                end
            end
        end
        checks++;
        if (pulses != 6) begin
            errors++;
            $display("FAIL saturation_pulses got %0d want 6", pulses);
        end
    endtask

    task automatic test_random();
        logic ev; logic [4:0] ew; longint ec;
        cyc(1'b1, 1'b0, 3'b0);
        for (int t = 0; t < 300; t++) begin
            cyc(($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom));
            for (int i = 0; i < 5; i++) begin
                model(lat_tab[i], cw_tab[i], ev, ew, ec);
                checks++;
                if (ov[i] !== ev || od[i] !== ew || oc[i] !== ec[31:0]) begin
                    errors++;
                    $display("FAIL random_model dut%0d t=%0d got v=%b d=%b c=%0d want v=%b d=%b c=%0d",
                             i, t, ov[i], od[i], oc[i], ev, ew, ec);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        valid_in    = 1'b0;
        data_bus_in = 3'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_latency_sweep();
        test_bubbles();
        test_reset_midflight();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
